// File: rtl/nodf_module_if.sv
// nodf_module_if: passive ap_ctrl_chain handshake monitor collecting transaction counts,
// latency, stall and idle statistics; everything freezes once finish has been seen.
module nodf_module_if #(
  parameter int CW = 32,
  parameter int LW = 32,
  parameter int OW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ap_start,
  input  logic          ap_ready,
  input  logic          ap_done,
  input  logic          ap_continue,
  input  logic          finish,
  output logic [1:0]    status,
  output logic [CW-1:0] start_cnt,
  output logic [CW-1:0] done_cnt,
  output logic [OW-1:0] outstanding,
  output logic [LW-1:0] last_lat,
  output logic [LW-1:0] max_lat,
  output logic [LW-1:0] min_lat,
  output logic [CW-1:0] cycle_cnt,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] idle_cnt,
  output logic          sample_valid,
  output logic [1:0]    err
);
  typedef enum logic [1:0] {IDLE, BUSY, STALL, FINISHED} state_t;
  state_t        status_q, status_d;
  logic [CW-1:0] start_cnt_q, start_cnt_d, done_cnt_q, done_cnt_d, cycle_cnt_q, cycle_cnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d, idle_cnt_q, idle_cnt_d;
  logic [OW-1:0] out_q, out_d;
  logic [LW-1:0] lat_q, lat_d, last_lat_q, last_lat_d, max_lat_q, max_lat_d, min_lat_q, min_lat_d;
  logic [LW-1:0] lat_cur;
  logic          sv_q, sv_d, fin, s, d;
  logic [1:0]    err_q, err_d;

  function automatic logic [CW-1:0] sat_c(input logic [CW-1:0] v, input logic en);
    return (en && !(&v)) ? v + CW'(1) : v;
  endfunction

  always_comb begin
    fin = status_q == FINISHED;
    s = ap_start & ap_ready & ~fin;
    d = ap_done & ap_continue & ~fin;
    // the start cycle itself counts as latency 1, so the timer is seeded combinationally
    lat_cur = (ap_start && status_q == IDLE) ? LW'(1) : lat_q;
    start_cnt_d = sat_c(start_cnt_q, s);
    done_cnt_d = sat_c(done_cnt_q, d);
    cycle_cnt_d = sat_c(cycle_cnt_q, ~fin);
    idle_cnt_d = sat_c(idle_cnt_q, status_q == IDLE);
    stall_cnt_d = sat_c(stall_cnt_q, status_q == STALL);
    out_d = (s && !d && !(&out_q)) ? out_q + OW'(1) :
            (d && !s && out_q != '0) ? out_q - OW'(1) : out_q;
    err_d = err_q | {s && !d && (&out_q), d && !s && out_q == '0};
    last_lat_d = d ? lat_cur : last_lat_q;
    max_lat_d = (d && lat_cur > max_lat_q) ? lat_cur : max_lat_q;
    min_lat_d = (d && lat_cur < min_lat_q) ? lat_cur : min_lat_q;
    lat_d = fin ? lat_q : (d && out_d != '0) ? LW'(1) : (&lat_cur) ? lat_cur : lat_cur + LW'(1);
    sv_d = d;
    status_d = (fin || finish) ? FINISHED :
               (ap_done && !ap_continue) ? STALL :
               (out_d != '0 || ap_start) ? BUSY : IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_q <= IDLE;
      start_cnt_q <= '0;
      done_cnt_q <= '0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      idle_cnt_q <= '0;
      out_q <= '0;
      lat_q <= '0;
      last_lat_q <= '0;
      max_lat_q <= '0;
      min_lat_q <= '1;
      sv_q <= 1'b0;
      err_q <= '0;
    end else begin
      status_q <= status_d;
      start_cnt_q <= start_cnt_d;
      done_cnt_q <= done_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      out_q <= out_d;
      lat_q <= lat_d;
      last_lat_q <= last_lat_d;
      max_lat_q <= max_lat_d;
      min_lat_q <= min_lat_d;
      sv_q <= sv_d;
      err_q <= err_d;
    end
  end

  assign status = status_q;
  assign start_cnt = start_cnt_q;
  assign done_cnt = done_cnt_q;
  assign outstanding = out_q;
  assign last_lat = last_lat_q;
  assign max_lat = max_lat_q;
  assign min_lat = min_lat_q;
  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign idle_cnt = idle_cnt_q;
  assign sample_valid = sv_q;
  assign err = err_q;
endmodule

// File: tb/tb_nodf_module_if.sv
// tb_nodf_module_if: directed scenarios against hand-computed statistics of nodf_module_if.
module tb_nodf_module_if;
  localparam int CW = 32;
  localparam int LW = 32;
  localparam int OW = 4;
  logic          clock = 1'b0;
  logic          reset, ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [1:0]    status, err;
  logic [CW-1:0] start_cnt, done_cnt, cycle_cnt, stall_cnt, idle_cnt;
  logic [OW-1:0] outstanding;
  logic [LW-1:0] last_lat, max_lat, min_lat;
  logic          sample_valid;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  always #5 clock = ~clock;

  nodf_module_if #(.CW(CW), .LW(LW), .OW(OW)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .status(status),
    .start_cnt(start_cnt), .done_cnt(done_cnt), .outstanding(outstanding),
    .last_lat(last_lat), .max_lat(max_lat), .min_lat(min_lat), .cycle_cnt(cycle_cnt),
    .stall_cnt(stall_cnt), .idle_cnt(idle_cnt), .sample_valid(sample_valid), .err(err)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_in();
    ap_start = 0;
    ap_ready = 0;
    ap_done = 0;
    ap_continue = 0;
  endtask

  task automatic apply_reset();
    idle_in();
    finish = 0;
    reset = 1;
    step(2);
    reset = 0;
  endtask

  // start accepted in cycle 0, done&continue in cycle lat-1
  task automatic txn(input int lat);
    ap_start = 1;
    ap_ready = 1;
    step();
    ap_start = 0;
    ap_ready = 0;
    step(lat - 2);
    ap_done = 1;
    ap_continue = 1;
    step();
    ap_done = 0;
    ap_continue = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++; if (status !== 2'd0) $display("FAIL reset_status got %0d want 0", status); else pass_cnt++;
    total_cnt++; if (cycle_cnt !== 0) $display("FAIL reset_cycle got %0d want 0", cycle_cnt); else pass_cnt++;
    total_cnt++; if (outstanding !== 0) $display("FAIL reset_outstanding got %0d want 0", outstanding); else pass_cnt++;
    step(10);
    total_cnt++; if (status !== 2'd0) $display("FAIL idle_status got %0d want 0", status); else pass_cnt++;
    total_cnt++; if (idle_cnt !== 10) $display("FAIL idle_cnt got %0d want 10", idle_cnt); else pass_cnt++;
    total_cnt++; if (cycle_cnt !== 10) $display("FAIL idle_cycle got %0d want 10", cycle_cnt); else pass_cnt++;
    total_cnt++; if (min_lat !== 32'hFFFF_FFFF) $display("FAIL reset_min_lat got %h want ffffffff", min_lat); else pass_cnt++;
    total_cnt++; if (err !== 2'b00) $display("FAIL reset_err got %b want 00", err); else pass_cnt++;
  endtask

  task automatic test_single();
    ap_start = 1;
    ap_ready = 1;
    step();
    ap_start = 0;
    ap_ready = 0;
    total_cnt++; if (status !== 2'd1) $display("FAIL single_busy got %0d want 1", status); else pass_cnt++;
    total_cnt++; if (outstanding !== 1) $display("FAIL single_out got %0d want 1", outstanding); else pass_cnt++;
    step(3);
    ap_done = 1;
    ap_continue = 1;
    step();
    ap_done = 0;
    ap_continue = 0;
    total_cnt++; if (start_cnt !== 1) $display("FAIL single_start got %0d want 1", start_cnt); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL single_done got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (last_lat !== 5) $display("FAIL single_last got %0d want 5", last_lat); else pass_cnt++;
    total_cnt++; if (max_lat !== 5) $display("FAIL single_max got %0d want 5", max_lat); else pass_cnt++;
    total_cnt++; if (min_lat !== 5) $display("FAIL single_min got %0d want 5", min_lat); else pass_cnt++;
    total_cnt++; if (sample_valid !== 1'b1) $display("FAIL single_sv_hi got %b want 1", sample_valid); else pass_cnt++;
    total_cnt++; if (outstanding !== 0) $display("FAIL single_out_end got %0d want 0", outstanding); else pass_cnt++;
    step();
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL single_sv_lo got %b want 0", sample_valid); else pass_cnt++;
    total_cnt++; if (status !== 2'd0) $display("FAIL single_idle got %0d want 0", status); else pass_cnt++;
  endtask

  task automatic test_lat_seq();
    apply_reset();
    txn(3);
    txn(7);
    txn(5);
    total_cnt++; if (last_lat !== 5) $display("FAIL seq_last got %0d want 5", last_lat); else pass_cnt++;
    total_cnt++; if (max_lat !== 7) $display("FAIL seq_max got %0d want 7", max_lat); else pass_cnt++;
    total_cnt++; if (min_lat !== 3) $display("FAIL seq_min got %0d want 3", min_lat); else pass_cnt++;
    total_cnt++; if (done_cnt !== 3) $display("FAIL seq_done got %0d want 3", done_cnt); else pass_cnt++;
    total_cnt++; if (start_cnt !== 3) $display("FAIL seq_start got %0d want 3", start_cnt); else pass_cnt++;
  endtask

  task automatic test_stall();
    apply_reset();
    ap_start = 1;
    ap_ready = 1;
    step();
    ap_start = 0;
    ap_ready = 0;
    step();
    ap_done = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++; if (status !== 2'd2) $display("FAIL stall_status_%0d got %0d want 2", i, status); else pass_cnt++;
    end
    total_cnt++; if (done_cnt !== 0) $display("FAIL stall_no_done got %0d want 0", done_cnt); else pass_cnt++;
    ap_continue = 1;
    step();
    ap_done = 0;
    ap_continue = 0;
    total_cnt++; if (stall_cnt !== 6) $display("FAIL stall_cnt got %0d want 6", stall_cnt); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL stall_done got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (last_lat !== 9) $display("FAIL stall_lat got %0d want 9", last_lat); else pass_cnt++;
    total_cnt++; if (status !== 2'd0) $display("FAIL stall_end got %0d want 0", status); else pass_cnt++;
    step(2);
    total_cnt++; if (done_cnt !== 1) $display("FAIL stall_done_once got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ap_start = 1;
    ap_ready = 1;
    step();
    ap_done = 1;
    ap_continue = 1;
    step();
    total_cnt++; if (outstanding !== 1) $display("FAIL b2b_out got %0d want 1", outstanding); else pass_cnt++;
    total_cnt++; if (start_cnt !== 2) $display("FAIL b2b_start got %0d want 2", start_cnt); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL b2b_done got %0d want 1", done_cnt); else pass_cnt++;
    ap_start = 0;
    ap_ready = 0;
    step();
    total_cnt++; if (outstanding !== 0) $display("FAIL b2b_drain got %0d want 0", outstanding); else pass_cnt++;
    total_cnt++; if (err !== 2'b00) $display("FAIL b2b_err_clean got %b want 00", err); else pass_cnt++;
    step();
    ap_done = 0;
    ap_continue = 0;
    total_cnt++; if (err !== 2'b01) $display("FAIL orphan_err got %b want 01", err); else pass_cnt++;
    total_cnt++; if (done_cnt !== 3) $display("FAIL orphan_done got %0d want 3", done_cnt); else pass_cnt++;
    total_cnt++; if (outstanding !== 0) $display("FAIL orphan_out got %0d want 0", outstanding); else pass_cnt++;
    step(3);
    total_cnt++; if (err !== 2'b01) $display("FAIL orphan_sticky got %b want 01", err); else pass_cnt++;
  endtask

  task automatic test_overflow();
    apply_reset();
    ap_start = 1;
    ap_ready = 1;
    step(15);
    total_cnt++; if (outstanding !== 15) $display("FAIL ovf_full got %0d want 15", outstanding); else pass_cnt++;
    total_cnt++; if (err !== 2'b00) $display("FAIL ovf_pre_err got %b want 00", err); else pass_cnt++;
    step();
    idle_in();
    total_cnt++; if (outstanding !== 15) $display("FAIL ovf_sat got %0d want 15", outstanding); else pass_cnt++;
    total_cnt++; if (err !== 2'b10) $display("FAIL ovf_err got %b want 10", err); else pass_cnt++;
    total_cnt++; if (start_cnt !== 16) $display("FAIL ovf_start got %0d want 16", start_cnt); else pass_cnt++;
  endtask

  task automatic test_finish();
    apply_reset();
    ap_start = 1;
    ap_ready = 1;
    step();
    ap_start = 0;
    ap_ready = 0;
    step();
    finish = 1;
    ap_done = 1;
    ap_continue = 1;
    step();
    finish = 0;
    total_cnt++; if (status !== 2'd3) $display("FAIL fin_status got %0d want 3", status); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL fin_edge_done got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (sample_valid !== 1'b1) $display("FAIL fin_edge_sv got %b want 1", sample_valid); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      ap_start = i[0];
      ap_ready = 1;
      ap_done = i[1];
      ap_continue = ~i[0];
      step();
    end
    idle_in();
    total_cnt++; if (status !== 2'd3) $display("FAIL frz_status got %0d want 3", status); else pass_cnt++;
    total_cnt++; if (cycle_cnt !== 3) $display("FAIL frz_cycle got %0d want 3", cycle_cnt); else pass_cnt++;
    total_cnt++; if (idle_cnt !== 1) $display("FAIL frz_idle got %0d want 1", idle_cnt); else pass_cnt++;
    total_cnt++; if (start_cnt !== 1) $display("FAIL frz_start got %0d want 1", start_cnt); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL frz_done got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (outstanding !== 0) $display("FAIL frz_out got %0d want 0", outstanding); else pass_cnt++;
    total_cnt++; if (last_lat !== 3) $display("FAIL frz_last got %0d want 3", last_lat); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 0) $display("FAIL frz_stall got %0d want 0", stall_cnt); else pass_cnt++;
    total_cnt++; if (err !== 2'b00) $display("FAIL frz_err got %b want 00", err); else pass_cnt++;
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL frz_sv got %b want 0", sample_valid); else pass_cnt++;
    #2 reset = 1;
    #1;
    total_cnt++; if (status !== 2'd0) $display("FAIL arst_status got %0d want 0", status); else pass_cnt++;
    total_cnt++; if (cycle_cnt !== 0) $display("FAIL arst_cycle got %0d want 0", cycle_cnt); else pass_cnt++;
    total_cnt++; if (start_cnt !== 0) $display("FAIL arst_start got %0d want 0", start_cnt); else pass_cnt++;
    total_cnt++; if (last_lat !== 0) $display("FAIL arst_last got %0d want 0", last_lat); else pass_cnt++;
    total_cnt++; if (max_lat !== 0) $display("FAIL arst_max got %0d want 0", max_lat); else pass_cnt++;
    total_cnt++; if (min_lat !== 32'hFFFF_FFFF) $display("FAIL arst_min got %h want ffffffff", min_lat); else pass_cnt++;
    step();
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    finish = 0;
    idle_in();
    test_reset();
    test_single();
    test_lat_seq();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_finish();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
